// File: rtl/avl_burst_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : avl_burst_reader_if
// Description : Bundles the command, return-stream and Avalon-MM read-master
//               signals of avl_burst_reader.
//               master modport : the burst reader itself
//               slave  modport : command source, stream consumer and Avalon
//                                slave seen from the environment
// Ports       : cmd_valid/cmd_ready/cmd_addr/cmd_len     command handshake
//               out_valid/out_ready/out_data              return stream
//               avm_address/avm_read/avm_write/avm_be/
//               avm_burstcount/avm_waitrequest/
//               avm_readdata/avm_readdatavalid            Avalon-MM master
// Revision    : 1.0  initial release
// ============================================================================
interface avl_burst_reader_if #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 576,
    parameter int LEN_WIDTH  = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0]    cmd_len;

    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_WIDTH-1:0]   out_data;

    logic [ADDR_WIDTH-1:0]   avm_address;
    logic                    avm_read;
    logic                    avm_write;
    logic [DATA_WIDTH/8-1:0] avm_be;
    logic [6:0]              avm_burstcount;
    logic                    avm_waitrequest;
    logic [DATA_WIDTH-1:0]   avm_readdata;
    logic                    avm_readdatavalid;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready,
        output out_valid, out_data,
        input  out_ready,
        output avm_address, avm_read, avm_write, avm_be, avm_burstcount,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready,
        input  out_valid, out_data,
        output out_ready,
        input  avm_address, avm_read, avm_write, avm_be, avm_burstcount,
        output avm_waitrequest, avm_readdata, avm_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/avl_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : avl_burst_reader
// Description : Avalon-MM burst read master. Splits a (word address, length)
//               command into bursts of at most BURST_MAX beats, issues them
//               only when the return FIFO is guaranteed room for every
//               outstanding beat, and streams returned beats out in order
//               through a first-word-fall-through FIFO.
// Ports       : clk, reset   clock, synchronous active-high reset
//               bus          avl_burst_reader_if.master (command, stream, Avalon)
//               busy         command in progress
//               done         one-cycle pulse when a command's beats are all in
//               err          sticky: readdatavalid arrived with nothing pending
// Revision    : 1.0  initial release
// ============================================================================
module avl_burst_reader #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 576,
    parameter int LEN_WIDTH  = 16,
    parameter int BURST_MAX  = 64,
    parameter int FIFO_DEPTH = 128
) (
    input  wire                clk,
    input  wire                reset,
    avl_burst_reader_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              SW      = CW + 2;
    localparam logic [6:0]      BMAX    = 7'(BURST_MAX);
    localparam logic [SW-1:0]   DEPTH_S = SW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state, state_next;

    logic [ADDR_WIDTH-1:0]   addr;          // next address not yet requested
    logic [LEN_WIDTH-1:0]    rem;           // beats not yet requested
    logic [CW-1:0]           pending;       // requested but not yet returned
    logic [CW-1:0]           fifo_count;
    logic [PW-1:0]           wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic                    read_q;
    logic [ADDR_WIDTH-1:0]   address_q;
    logic [6:0]              bcount_q;

    logic                    cmd_ready, cmd_take, accept, push, pop;
    logic [ADDR_WIDTH-1:0]   addr_after;
    logic [LEN_WIDTH-1:0]    rem_after;
    logic [6:0]              blen_next;
    logic [CW-1:0]           pending_next, fifo_next;
    logic [SW-1:0]           credit_sum;
    logic                    credit_ok;
    logic                    read_next, read_load, done_next;

    // Holding cmd_ready low during the done cycle means a new command is
    // only taken the cycle after done.
    assign cmd_ready = (state == IDLE) && !done;
    assign cmd_take  = bus.cmd_valid && cmd_ready;
    assign accept    = read_q && !bus.avm_waitrequest;
    assign push      = bus.avm_readdatavalid && (pending != '0);
    assign pop       = (fifo_count != '0) && bus.out_ready;

    // Look-ahead values as they will stand after this cycle; the next burst
    // is sized and credited against them so bursts can go back-to-back.
    assign addr_after   = accept ? addr + ADDR_WIDTH'(bcount_q) : addr;
    assign rem_after    = accept ? rem - LEN_WIDTH'(bcount_q) : rem;
    assign blen_next    = (rem_after > LEN_WIDTH'(BURST_MAX)) ? BMAX : rem_after[6:0];
    assign pending_next = pending + (accept ? CW'(bcount_q) : CW'(0)) - (push ? CW'(1) : CW'(0));
    assign fifo_next    = fifo_count + CW'(push) - CW'(pop);
    assign credit_sum   = SW'(fifo_next) + SW'(pending_next) + SW'(blen_next);
    assign credit_ok    = (credit_sum <= DEPTH_S);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        read_next  = 1'b0;
        read_load  = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_take) begin
                    if (bus.cmd_len == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (read_q && bus.avm_waitrequest) begin
                    read_next = 1'b1;              // stalled: hold request as is
                end else if (rem_after == '0) begin
                    state_next = DRAIN;
                end else if (credit_ok) begin
                    read_next = 1'b1;
                    read_load = 1'b1;
                end
            end
            DRAIN: begin
                if (pending == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr       <= '0;
            rem        <= '0;
            pending    <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            read_q     <= 1'b0;
            address_q  <= '0;
            bcount_q   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (cmd_take) begin
                addr <= bus.cmd_addr;
                rem  <= bus.cmd_len;
            end else begin
                addr <= addr_after;
                rem  <= rem_after;
            end
            read_q <= read_next;
            if (read_load) begin
                address_q <= addr_after;
                bcount_q  <= blen_next;
            end
            pending    <= pending_next;
            fifo_count <= fifo_next;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            done <= done_next;
            if (bus.avm_readdatavalid && (pending == '0)) begin
                err <= 1'b1;
            end
        end
    end

    // Storage is not reset; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.avm_readdata;
        end
    end

    assign bus.cmd_ready      = cmd_ready;
    assign bus.out_valid      = (fifo_count != '0);
    assign bus.out_data       = mem[rd_ptr];
    assign bus.avm_address    = address_q;
    assign bus.avm_read       = read_q;
    assign bus.avm_burstcount = bcount_q;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_be         = '1;
    assign busy               = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_avl_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_avl_burst_reader
// Description : Self-checking bench for avl_burst_reader. A driver issues
//               directed commands and pushes the expected bursts and beats;
//               an Avalon slave model checks bursts and returns data two
//               cycles after accept; a monitor pops and compares out beats.
// Revision    : 1.0  initial release
// ============================================================================
module tb_avl_burst_reader;
    localparam int AW = 27;
    localparam int DW = 576;
    localparam int LW = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [6:0]    bc;
    } burst_t;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } rb_t;

    logic clk = 1'b0;
    logic reset;
    logic busy, done, err;

    avl_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

    avl_burst_reader #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
        .BURST_MAX(64), .FIFO_DEPTH(128)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] sb_q[$];
    burst_t        bq[$];
    rb_t           rq[$];

    // slave model state
    int            scyc = 0;
    int            last_due = 0;
    int            acc_cnt = 0;
    int            req_beats = 0;
    int            stall_idx = -1;
    int            stall_len = 0;
    int            stall_ctr = 0;
    int            stray_cnt = 0;
    int            stray_done = 0;
    logic [AW-1:0] hold_a;
    logic [6:0]    hold_bc;

    // monitor state
    int            mcyc = 0;
    int            done_cnt = 0;
    int            read_cycles = 0;
    int            last_pop_cyc = 0;
    int            last_done_cyc = 0;
    logic [DW-1:0] exp_d;

    function automatic logic [DW-1:0] beat(input logic [AW-1:0] a);
        logic [31:0] w;
        w = {5'd0, a} ^ 32'h5A00_0000;
        return {18{w}};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_beats(input logic [AW-1:0] a, input int l);
        for (int i = 0; i < l; i++) begin
            sb_q.push_back(beat(a + AW'(i)));
        end
    endtask

    task automatic push_burst(input logic [AW-1:0] a, input logic [6:0] bc);
        burst_t b;
        b.a  = a;
        b.bc = bc;
        bq.push_back(b);
    endtask

    task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept", 64'(n < 200), 64'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            #3;
            n++;
        end
        chk({nm, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk({nm, "_beats_left"}, 64'(sb_q.size()), 64'd0);
        chk({nm, "_bursts_left"}, 64'(bq.size()), 64'd0);
    endtask

    // Avalon slave model: acts at negedge+1 on the current cycle's request.
    initial begin
        burst_t eb;
        int     due;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = '0;
        forever begin
            @(negedge clk);
            #1;
            scyc++;
            if (reset) begin
                rq.delete();
                last_due              = 0;
                bus.avm_waitrequest   = 1'b0;
                bus.avm_readdatavalid = 1'b0;
            end else begin
                bus.avm_waitrequest = 1'b0;
                if (bus.avm_read) begin
                    if (acc_cnt == stall_idx && stall_ctr < stall_len) begin
                        if (stall_ctr == 0) begin
                            hold_a  = bus.avm_address;
                            hold_bc = bus.avm_burstcount;
                        end else begin
                            chk("stall_addr", 64'(bus.avm_address), 64'(hold_a));
                            chk("stall_bc", 64'(bus.avm_burstcount), 64'(hold_bc));
                        end
                        bus.avm_waitrequest = 1'b1;
                        stall_ctr++;
                    end else begin
                        if (acc_cnt == stall_idx) begin
                            chk("stall_accept_addr", 64'(bus.avm_address), 64'(hold_a));
                            chk("stall_accept_bc", 64'(bus.avm_burstcount), 64'(hold_bc));
                        end
                        if (bq.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL burst_unexpected: got addr %0h bc %0d expected no burst",
                                     bus.avm_address, bus.avm_burstcount);
                        end else begin
                            eb = bq.pop_front();
                            chk("burst_addr", 64'(bus.avm_address), 64'(eb.a));
                            chk("burst_bc", 64'(bus.avm_burstcount), 64'(eb.bc));
                        end
                        for (int i = 0; i < int'(bus.avm_burstcount); i++) begin
                            due = (scyc + 2 > last_due + 1) ? scyc + 2 : last_due + 1;
                            rq.push_back('{a: bus.avm_address + AW'(i), due: due});
                            last_due = due;
                        end
                        acc_cnt++;
                        req_beats += int'(bus.avm_burstcount);
                    end
                end
                bus.avm_readdatavalid = 1'b0;
                if (stray_cnt != stray_done) begin
                    stray_done            = stray_cnt;
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata      = {DW{1'b1}};
                end else if (rq.size() != 0 && rq[0].due <= scyc) begin
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata      = beat(rq[0].a);
                    void'(rq.pop_front());
                end
            end
        end
    end

    // Output monitor: compares every popped beat against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            mcyc++;
            if (!reset) begin
                if (bus.out_valid && bus.out_ready) begin
                    last_pop_cyc = mcyc;
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL data_unexpected: got %h expected no beat", bus.out_data);
                    end else begin
                        exp_d = sb_q.pop_front();
                        if (bus.out_data !== exp_d) begin
                            n_bad++;
                            $display("FAIL data: got %h expected %h", bus.out_data, exp_d);
                        end
                    end
                end
                if (done) begin
                    done_cnt++;
                    last_done_cyc = mcyc;
                end
                if (bus.avm_read) begin
                    read_cycles++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, a0, n;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #3;
        chk("rst_avm_read", 64'(bus.avm_read), 64'd0);
        chk("rst_avm_address", 64'(bus.avm_address), 64'd0);
        chk("rst_avm_bc", 64'(bus.avm_burstcount), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("avm_write", 64'(bus.avm_write), 64'd0);
        chk("avm_be_ones", 64'(&bus.avm_be), 64'd1);

        // 1: single short burst
        d0 = done_cnt;
        push_burst(27'h100, 7'd3);
        push_beats(27'h100, 3);
        send_cmd(27'h100, 16'd3);
        #3;
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", d0);
        wait_drain("t1");
        chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t1_done_after_last_beat", 64'(last_done_cyc - last_pop_cyc), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);

        // 2: length split into 64/64/22
        d0 = done_cnt;
        push_burst(27'h000, 7'd64);
        push_burst(27'h040, 7'd64);
        push_burst(27'h080, 7'd22);
        push_beats(27'h000, 150);
        send_cmd(27'h000, 16'd150);
        wait_done("t2", d0);
        wait_drain("t2");
        chk("t2_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 3: consumer stalled, credit limits outstanding to FIFO depth
        d0 = done_cnt;
        r0 = req_beats;
        bus.out_ready = 1'b0;
        push_burst(27'h1000, 7'd64);
        push_burst(27'h1040, 7'd64);
        push_burst(27'h1080, 7'd64);
        push_burst(27'h10C0, 7'd8);
        push_beats(27'h1000, 200);
        send_cmd(27'h1000, 16'd200);
        repeat (250) @(negedge clk);
        #3;
        chk("t3_req_beats", 64'(req_beats - r0), 64'd128);
        chk("t3_read_low", 64'(bus.avm_read), 64'd0);
        chk("t3_out_valid", 64'(bus.out_valid), 64'd1);
        chk("t3_bursts_held", 64'(bq.size()), 64'd2);
        @(negedge clk);
        bus.out_ready = 1'b1;
        wait_done("t3", d0);
        wait_drain("t3");
        chk("t3_req_total", 64'(req_beats - r0), 64'd200);
        chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);

        // 4: waitrequest held 5 cycles on the second burst
        d0        = done_cnt;
        stall_len = 5;
        stall_idx = acc_cnt + 1;
        push_burst(27'h2000, 7'd64);
        push_burst(27'h2040, 7'd64);
        push_burst(27'h2080, 7'd2);
        push_beats(27'h2000, 130);
        send_cmd(27'h2000, 16'd130);
        wait_done("t4", d0);
        wait_drain("t4");
        chk("t4_stall_cycles", 64'(stall_ctr), 64'd5);
        chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
        stall_idx = -1;

        // 5: zero-length command, then stray readdatavalid while idle
        d0 = done_cnt;
        r0 = read_cycles;
        send_cmd(27'h777, 16'd0);
        #3;
        chk("t5_done_pulse", 64'(done), 64'd1);
        chk("t5_cmd_ready_in_done", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        #3;
        chk("t5_done_low", 64'(done), 64'd0);
        chk("t5_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        chk("t5_no_read", 64'(read_cycles - r0), 64'd0);
        chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t5_err_before", 64'(err), 64'd0);
        @(negedge clk);
        stray_cnt++;
        @(negedge clk);
        #3;
        chk("t5_err_set", 64'(err), 64'd1);
        chk("t5_fifo_empty", 64'(bus.out_valid), 64'd0);

        // 6: reset in the middle of a command, then a normal command
        push_burst(27'h3000, 7'd64);
        push_burst(27'h3040, 7'd36);
        push_beats(27'h3000, 100);
        a0 = acc_cnt;
        send_cmd(27'h3000, 16'd100);
        n = 0;
        while (acc_cnt == a0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_first_accept", 64'(acc_cnt != a0), 64'd1);
        chk("t6_busy_mid", 64'(busy), 64'd1);
        reset = 1'b1;
        sb_q.delete();
        bq.delete();
        @(negedge clk);
        reset = 1'b0;
        #3;
        chk("t6_rst_avm_read", 64'(bus.avm_read), 64'd0);
        chk("t6_rst_avm_address", 64'(bus.avm_address), 64'd0);
        chk("t6_rst_avm_bc", 64'(bus.avm_burstcount), 64'd0);
        chk("t6_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_busy_done_err", 64'({busy, done, err}), 64'd0);
        d0 = done_cnt;
        push_burst(27'h500, 7'd5);
        push_beats(27'h500, 5);
        send_cmd(27'h500, 16'd5);
        wait_done("t6", d0);
        wait_drain("t6");
        chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);
        chk("t6_err_clear", 64'(err), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
